// File: rtl/timer_555_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_555_pkg
// Description : Shared types and constants for the multi-channel 555 timer
//               emulator: channel FSM state encoding and MODE input values.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_555_pkg;

    // Channel FSM states. OUT is high only in HIGH; DONE is high only in END.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        END  = 2'd3
    } state_t;

    // Values of the per-channel MODE input
    localparam logic MODE_MONO    = 1'b0;
    localparam logic MODE_ASTABLE = 1'b1;

endpackage : timer_555_pkg
`default_nettype wire

// File: rtl/timer_555_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_555_channel
// Description : One 555-timer channel. Monostable (falling-edge trigger on
//               trg_n) or astable (free-running high/low) operation, with
//               durations latched at every phase entry.
//               Optional macro TIMER_555_RETRIGGER_EN makes the monostable
//               retriggerable: a trigger in HIGH restarts the high phase, and
//               a trigger in END starts a new high phase at once.
// Ports       : clk     - counting clock
//               rst_n   - asynchronous active-low reset
//               trg_n   - trigger, active on falling edge (synchronous to clk)
//               en      - enable; low forces IDLE
//               mode    - 0 = monostable, 1 = astable
//               hi_cnt  - high duration in cycles (0 behaves as 1)
//               lo_cnt  - astable low duration in cycles (0 behaves as 1)
//               out     - timer output
//               done    - one-cycle pulse after a monostable high phase
// Revision    : 1.0 - initial release
// ============================================================================
module timer_555_channel
    import timer_555_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trg_n,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] hi_cnt,
    input  logic [CNT_W-1:0] lo_cnt,
    output logic             out,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] lat_next;
    logic             prev_trg_n;
    logic             detect;
    logic             phase_end;
    logic [CNT_W-1:0] hi_eff;
    logic [CNT_W-1:0] lo_eff;

    // History resets to 1 so a released reset never looks like a falling edge
    assign detect    = prev_trg_n & ~trg_n;
    assign hi_eff    = (hi_cnt == '0) ? ONE : hi_cnt;
    assign lo_eff    = (lo_cnt == '0) ? ONE : lo_cnt;
    // Counter starts at 0 on phase entry, so the phase lasts 'lat' cycles
    assign phase_end = (cnt == (lat - ONE));

    // ------------------------------------------------------------------
    // State register (plus counter, latched duration, trigger history)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat        <= ONE;
            prev_trg_n <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            lat        <= lat_next;
            prev_trg_n <= trg_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt + ONE;
        lat_next   = lat;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (mode == MODE_ASTABLE || detect) begin
                    state_next = HIGH;
                    lat_next   = hi_eff;
                end
            end

            HIGH: begin
`ifdef TIMER_555_RETRIGGER_EN
                if (mode == MODE_MONO && detect) begin
                    // Restart the pulse, measured from this trigger
                    cnt_next = '0;
                    lat_next = hi_eff;
                end else
`endif
                if (phase_end) begin
                    cnt_next = '0;
                    if (mode == MODE_ASTABLE) begin
                        state_next = LOW;
                        lat_next   = lo_eff;
                    end else begin
                        state_next = END;
                    end
                end
            end

            LOW: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (mode == MODE_ASTABLE) begin
                        state_next = HIGH;
                        lat_next   = hi_eff;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            END: begin
                cnt_next   = '0;
                state_next = IDLE;
`ifdef TIMER_555_RETRIGGER_EN
                if (detect) begin
                    state_next = HIGH;
                    lat_next   = hi_eff;
                end
`endif
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        // Disable wins over everything, including a simultaneous trigger
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        out  = (state == HIGH);
        done = (state == END);
    end

endmodule : timer_555_channel
`default_nettype wire

// File: rtl/timer_555_multi.sv
`default_nettype none
// ============================================================================
// Module      : timer_555_multi
// Description : Multi-channel 555-timer emulator. Instantiates CHANNELS
//               independent timer_555_channel blocks sharing one clock and
//               reset, and unpacks the per-channel duration buses.
//               Optional macro TIMER_555_RETRIGGER_EN selects retriggerable
//               monostable behaviour in every channel.
// Ports       : CLK    - counting clock
//               RST_N  - asynchronous active-low reset
//               TRG_N  - per-channel trigger (falling edge, monostable)
//               EN     - per-channel enable
//               MODE   - per-channel mode (0 mono, 1 astable)
//               HI_CNT - per-channel high duration, ch i at [i*CNT_W +: CNT_W]
//               LO_CNT - per-channel low duration, same packing
//               OUT    - per-channel timer output
//               DONE   - per-channel end-of-oneshot pulse
// Revision    : 1.0 - initial release
// ============================================================================
module timer_555_multi
    import timer_555_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS-1:0]       TRG_N,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       MODE,
    input  logic [CHANNELS*CNT_W-1:0] HI_CNT,
    input  logic [CHANNELS*CNT_W-1:0] LO_CNT,
    output logic [CHANNELS-1:0]       OUT,
    output logic [CHANNELS-1:0]       DONE
);

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            timer_555_channel #(
                .CNT_W (CNT_W)
            ) u_channel (
                .clk    (CLK),
                .rst_n  (RST_N),
                .trg_n  (TRG_N[g]),
                .en     (EN[g]),
                .mode   (MODE[g]),
                .hi_cnt (HI_CNT[g*CNT_W +: CNT_W]),
                .lo_cnt (LO_CNT[g*CNT_W +: CNT_W]),
                .out    (OUT[g]),
                .done   (DONE[g])
            );
        end
    endgenerate

endmodule : timer_555_multi
`default_nettype wire

// File: tb/tb_timer_555_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_555_multi
// Description : Self-checking bench for timer_555_multi. A reference model
//               tracks, per channel, the remaining cycles of the current high
//               or low phase and whether a DONE pulse is showing, and is
//               stepped once per clock from the same inputs as the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_555_multi;

    localparam int CH = 4;
    localparam int W  = 16;
`ifdef TIMER_555_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [CH-1:0]   TRG_N;
    logic [CH-1:0]   EN;
    logic [CH-1:0]   MODE;
    logic [CH*W-1:0] HI_CNT;
    logic [CH*W-1:0] LO_CNT;
    logic [CH-1:0]   OUT;
    logic [CH-1:0]   DONE;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_hi_left [CH];   // cycles of high output still to show (incl. now)
    int m_lo_left [CH];   // cycles of astable low still to show (incl. now)
    bit m_done    [CH];   // DONE pulse showing now
    bit m_prev    [CH];   // previous TRG_N

    timer_555_multi #(
        .CHANNELS (CH),
        .CNT_W    (W)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .TRG_N  (TRG_N),
        .EN     (EN),
        .MODE   (MODE),
        .HI_CNT (HI_CNT),
        .LO_CNT (LO_CNT),
        .OUT    (OUT),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_hi_left[i] = 0;
            m_lo_left[i] = 0;
            m_done[i]    = 1'b0;
            m_prev[i]    = 1'b1;
        end
    endfunction

    // Advance the model by one clock using the inputs held during the cycle
    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            bit det;
            int hi;
            int lo;
            det = m_prev[i] & ~TRG_N[i];
            m_prev[i] = TRG_N[i];
            hi = eff(int'(HI_CNT[i*W +: W]));
            lo = eff(int'(LO_CNT[i*W +: W]));
            if (!EN[i]) begin
                m_hi_left[i] = 0;
                m_lo_left[i] = 0;
                m_done[i]    = 1'b0;
            end else if (m_hi_left[i] > 0) begin
                if (RETRIG && !MODE[i] && det) begin
                    m_hi_left[i] = hi;
                end else if (m_hi_left[i] == 1) begin
                    m_hi_left[i] = 0;
                    if (MODE[i]) m_lo_left[i] = lo;
                    else         m_done[i]    = 1'b1;
                end else begin
                    m_hi_left[i] = m_hi_left[i] - 1;
                end
            end else if (m_lo_left[i] > 0) begin
                if (m_lo_left[i] == 1) begin
                    m_lo_left[i] = 0;
                    if (MODE[i]) m_hi_left[i] = hi;
                end else begin
                    m_lo_left[i] = m_lo_left[i] - 1;
                end
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
                if (RETRIG && det) m_hi_left[i] = hi;
            end else begin
                if (MODE[i] || det) m_hi_left[i] = hi;
            end
        end
    endfunction

    // One clock: model follows the DUT edge; return at the sampling edge
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic set_hi(input int ch, input int v);
        HI_CNT[ch*W +: W] = W'(v);
    endtask

    task automatic set_lo(input int ch, input int v);
        LO_CNT[ch*W +: W] = W'(v);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        // Power-on reset state
        checks++;
        if (OUT !== 4'b0000 || DONE !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state OUT=%b DONE=%b required 0000/0000", OUT, DONE);
        end
        RST_N = 1'b1;
        EN[0] = 1'b1; MODE[0] = 1'b0; set_hi(0, 10);
        TRG_N[0] = 1'b0;
        tick();
        TRG_N[0] = 1'b1;
        repeat (3) tick();
        checks++;
        if (OUT[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_midhigh OUT0=%b required 1", OUT[0]);
        end
        // Asynchronous assertion in the middle of a clock phase
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if (OUT !== 4'b0000 || DONE !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async OUT=%b DONE=%b required 0000/0000", OUT, DONE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (OUT[0] !== 1'b0 || DONE[0] !== 1'b0 || OUT[0] !== (m_hi_left[0] > 0)) begin
                errors++;
                $display("FAIL reset_release k=%0d OUT0=%b DONE0=%b required 0/0", k, OUT[0], DONE[0]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mono_retrigger();
        bit eo;
        bit ed;
        EN[0] = 1'b1; MODE[0] = 1'b0; set_hi(0, 5);
        TRG_N[0] = 1'b0;
        tick();
        TRG_N[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            eo = RETRIG ? (k <= 8) : (k <= 5);
            ed = RETRIG ? (k == 9) : (k == 6);
            checks++;
            if (OUT[0] !== eo || DONE[0] !== ed) begin
                errors++;
                $display("FAIL mono t+%0d OUT0=%b DONE0=%b required %b/%b", k, OUT[0], DONE[0], eo, ed);
            end
            checks++;
            if (OUT[0] !== (m_hi_left[0] > 0) || DONE[0] !== m_done[0]) begin
                errors++;
                $display("FAIL mono_model t+%0d OUT0=%b DONE0=%b model %b/%b",
                         k, OUT[0], DONE[0], (m_hi_left[0] > 0), m_done[0]);
            end
            TRG_N[0] = (k == 3) ? 1'b0 : 1'b1;
            tick();
        end
        TRG_N[0] = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_astable();
        bit eo;
        MODE[1] = 1'b1; set_hi(1, 3); set_lo(1, 2);
        EN[1] = 1'b1;
        tick();
        for (int k = 1; k <= 21; k++) begin
            if (k <= 15) eo = ((k - 1) % 5) < 3;
            else         eo = ((k - 16) % 6) < 4;
            checks++;
            if (OUT[1] !== eo || DONE[1] !== 1'b0) begin
                errors++;
                $display("FAIL astable k=%0d OUT1=%b DONE1=%b required %b/0", k, OUT[1], DONE[1], eo);
            end
            // First cycle of the third high phase: new duration applies next time
            if (k == 11) set_hi(1, 4);
            tick();
        end
        EN[1] = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_zero_disable();
        EN[2] = 1'b1; MODE[2] = 1'b0; set_hi(2, 0);
        TRG_N[2] = 1'b0;
        tick();
        TRG_N[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (OUT[2] !== (k == 1) || DONE[2] !== (k == 2)) begin
                errors++;
                $display("FAIL zero_pulse t+%0d OUT2=%b DONE2=%b required %b/%b",
                         k, OUT[2], DONE[2], (k == 1), (k == 2));
            end
            tick();
        end
        // Astable disabled during its low phase
        MODE[3] = 1'b1; set_hi(3, 2); set_lo(3, 3);
        EN[3] = 1'b1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (OUT[3] !== (k <= 2)) begin
                errors++;
                $display("FAIL disable_pre k=%0d OUT3=%b required %b", k, OUT[3], (k <= 2));
            end
            if (k == 3) EN[3] = 1'b0;
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (OUT[3] !== 1'b0 || DONE[3] !== 1'b0 || OUT[3] !== (m_hi_left[3] > 0)) begin
                errors++;
                $display("FAIL disable_post k=%0d OUT3=%b DONE3=%b required 0/0", k, OUT[3], DONE[3]);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_all_channels();
        for (int i = 0; i < CH; i++) begin
            EN[i] = 1'b1;
            MODE[i] = i[0];
            set_hi(i, i + 2);
            set_lo(i, 5 - i);
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < CH; i++) begin
                TRG_N[i] = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 39) == 0) EN[i] = ~EN[i];
                if ($urandom_range(0, 59) == 0) MODE[i] = ~MODE[i];
                if ($urandom_range(0, 7) == 0) set_hi(i, int'($urandom_range(0, 7)));
                if ($urandom_range(0, 7) == 0) set_lo(i, int'($urandom_range(0, 7)));
            end
            tick();
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (OUT[i] !== (m_hi_left[i] > 0) || DONE[i] !== m_done[i]) begin
                    errors++;
                    $display("FAIL random c=%0d ch=%0d OUT=%b DONE=%b required %b/%b",
                             c, i, OUT[i], DONE[i], (m_hi_left[i] > 0), m_done[i]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        RST_N  = 1'b0;
        TRG_N  = '1;
        EN     = '0;
        MODE   = '0;
        HI_CNT = '0;
        LO_CNT = '0;
        model_reset();
        repeat (3) @(negedge CLK);

        test_reset();
        test_mono_retrigger();
        test_astable();
        test_zero_disable();
        test_random_all_channels();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_timer_555_multi
`default_nettype wire
